// File: rtl/dphy_seq_pkg.sv
// Shared types and helpers for the D-PHY lane power-up/down sequencer.
package dphy_seq_pkg;

   localparam int unsigned MAX_LANES = 8;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ENABLE_LANES,
      ST_WAIT_CLK_ACTIVE,
      ST_LANES_ACTIVE,
      ST_WAIT_DATA_IDLE,
      ST_WAIT_CLK_INACTIVE,
      ST_ULPS,
      ST_ULPS_WAKEUP,
      ST_DISABLE_BUFFERS,
      ST_ERROR
   } seq_state_e;

   // Thermometer mask of n lanes, n = clamp(req, 1, num); lane 0 is always present.
   function automatic logic [MAX_LANES-1:0] lane_mask_f(input logic [3:0] req,
                                                        input logic [3:0] num);
      logic [3:0]           n;
      logic [MAX_LANES-1:0] m;
      n = req;
      if (n == 4'd0) n = 4'd1;
      if (n > num)   n = num;
      if (n == 4'd0) n = 4'd1;
      for (int i = 0; i < int'(MAX_LANES); i++) begin
         m[i] = (4'(i) < n);
      end
      return m;
   endfunction

endpackage

// File: rtl/dphy_seq_timer.sv
// Load/decrement counter that saturates at zero; flags the cycle it reaches zero.
module dphy_seq_timer #(
   parameter int unsigned TMR_W = 16
) (
   input  logic             clk_phy,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [TMR_W-1:0] load_val_i,
   output logic             zero_o,
   output logic             expire_o
);

   logic [TMR_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (count_q != '0) begin
         count_d = count_q - TMR_W'(1);
      end
   end

   always_ff @(posedge clk_phy or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero_o   = (count_q == '0);
   assign expire_o = (count_q == TMR_W'(1));

endmodule

// File: rtl/dphy_lanes_sequencer.sv
// D-PHY lane sequencer: brings clock and data lanes through enable, HS, ULPS and shutdown.
module dphy_lanes_sequencer
   import dphy_seq_pkg::*;
#(
   parameter int unsigned NUM_LANES = 4,
   parameter int unsigned TMR_W     = 16
) (
   input  logic                 clk_phy,
   input  logic                 rst_n,
   input  logic                 lines_enable,
   input  logic                 clock_enable,
   input  logic                 ulps_request,
   input  logic [3:0]           reg_lanes_number,
   input  logic [TMR_W-1:0]     seq_timeout,
   input  logic [TMR_W-1:0]     wakeup_time,
   input  logic [NUM_LANES-1:0] data_lane_ready,
   input  logic [NUM_LANES-1:0] data_lane_active,
   input  logic                 clk_lane_ready,
   input  logic                 clk_lane_active,
   output logic [NUM_LANES-1:0] data_lines_enable,
   output logic [NUM_LANES-1:0] data_ulps_rqst,
   output logic                 clk_lines_enable,
   output logic                 clk_start_rqst,
   output logic                 clk_fin_rqst,
   output logic                 clk_ulps_rqst,
   output logic                 lines_ready,
   output logic                 clock_ready,
   output logic                 lanes_active,
   output logic                 ulps_active,
   output logic                 seq_error,
   output logic [NUM_LANES-1:0] lane_mask
);

   seq_state_e           state_q, state_d;
   logic [NUM_LANES-1:0] mask_q, mask_d;
   logic                 tmr_load_c;
   logic [TMR_W-1:0]     tmr_val_c;
   logic                 tmr_zero, tmr_expire;
   logic                 all_ready_c, any_active_c, timeout_c;

   // Lanes outside the latched mask never influence the sequence.
   assign all_ready_c  = (&(data_lane_ready | ~mask_q)) & clk_lane_ready;
   assign any_active_c = |(data_lane_active & mask_q);
   assign timeout_c    = (seq_timeout != '0) & tmr_expire;

   dphy_seq_timer #(.TMR_W(TMR_W)) u_timer (
      .clk_phy    (clk_phy),
      .rst_n      (rst_n),
      .load_i     (tmr_load_c),
      .load_val_i (tmr_val_c),
      .zero_o     (tmr_zero),
      .expire_o   (tmr_expire)
   );

   always_comb begin
      state_d    = state_q;
      mask_d     = mask_q;
      tmr_load_c = 1'b0;
      tmr_val_c  = seq_timeout;
      unique case (state_q)
         ST_IDLE: begin
            if (lines_enable) begin
               state_d = ST_ENABLE_LANES;
               mask_d  = NUM_LANES'(lane_mask_f(reg_lanes_number, 4'(NUM_LANES)));
            end
         end
         ST_ENABLE_LANES: begin
            if (all_ready_c && clock_enable) state_d = ST_WAIT_CLK_ACTIVE;
            else if (timeout_c)              state_d = ST_ERROR;
         end
         ST_WAIT_CLK_ACTIVE: begin
            if (clk_lane_active) state_d = ST_LANES_ACTIVE;
            else if (timeout_c)  state_d = ST_ERROR;
         end
         ST_LANES_ACTIVE: begin
            // Clock stop outranks a simultaneous ULPS request.
            if (!clock_enable || !lines_enable)  state_d = ST_WAIT_DATA_IDLE;
            else if (ulps_request && !any_active_c) state_d = ST_ULPS;
         end
         ST_WAIT_DATA_IDLE: begin
            if (!any_active_c)  state_d = ST_WAIT_CLK_INACTIVE;
            else if (timeout_c) state_d = ST_ERROR;
         end
         ST_WAIT_CLK_INACTIVE: begin
            if (!clk_lane_active) state_d = lines_enable ? ST_ENABLE_LANES : ST_DISABLE_BUFFERS;
            else if (timeout_c)   state_d = ST_ERROR;
         end
         ST_ULPS: begin
            if (!ulps_request) state_d = ST_ULPS_WAKEUP;
         end
         ST_ULPS_WAKEUP: begin
            if (tmr_zero) state_d = ST_WAIT_CLK_ACTIVE;
         end
         ST_DISABLE_BUFFERS: state_d = ST_IDLE;
         ST_ERROR: begin
            if (!lines_enable) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // The one timer serves both the handshake timeouts and the ULPS exit hold.
      if (state_d != state_q) begin
         unique case (state_d)
            ST_ENABLE_LANES, ST_WAIT_CLK_ACTIVE,
            ST_WAIT_DATA_IDLE, ST_WAIT_CLK_INACTIVE: tmr_load_c = 1'b1;
            ST_ULPS_WAKEUP: begin
               tmr_load_c = 1'b1;
               tmr_val_c  = wakeup_time;
            end
            default: tmr_load_c = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk_phy or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         mask_q  <= '0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
      end
   end

   // Moore decode from the registered state and latched mask.
   always_comb begin
      data_lines_enable = '0;
      data_ulps_rqst    = '0;
      clk_lines_enable  = 1'b0;
      clk_start_rqst    = 1'b0;
      clk_fin_rqst      = 1'b0;
      clk_ulps_rqst     = 1'b0;
      clock_ready       = 1'b0;
      ulps_active       = 1'b0;
      seq_error         = 1'b0;
      if (state_q != ST_IDLE && state_q != ST_DISABLE_BUFFERS && state_q != ST_ERROR) begin
         data_lines_enable = mask_q;
         clk_lines_enable  = 1'b1;
      end
      if (state_q == ST_WAIT_CLK_ACTIVE || state_q == ST_LANES_ACTIVE) clk_start_rqst = 1'b1;
      if (state_q == ST_WAIT_CLK_INACTIVE) clk_fin_rqst = 1'b1;
      if (state_q == ST_ULPS) begin
         data_ulps_rqst = mask_q;
         clk_ulps_rqst  = 1'b1;
         ulps_active    = 1'b1;
      end
      if (state_q == ST_LANES_ACTIVE) clock_ready = 1'b1;
      if (state_q == ST_ERROR)        seq_error   = 1'b1;
   end

   assign lines_ready  = all_ready_c & clk_lines_enable;
   assign lanes_active = any_active_c;
   assign lane_mask    = mask_q;

endmodule

// File: tb/tb_dphy_lanes_sequencer.sv
// Scoreboard bench for dphy_lanes_sequencer: per-cycle expected output vectors.
module tb_dphy_lanes_sequencer;

   localparam int unsigned NL = 4;
   localparam int unsigned TW = 16;

   typedef enum int {P_IDLE, P_EN, P_WCA, P_LA, P_WDI, P_WCI, P_ULPS, P_WAKE, P_DIS, P_ERR} ph_e;
   typedef struct {
      string       tag;
      logic [20:0] exp;
   } sb_t;

   logic          clk_phy = 1'b0;
   logic          rst_n;
   logic          lines_enable, clock_enable, ulps_request;
   logic [3:0]    reg_lanes_number;
   logic [TW-1:0] seq_timeout, wakeup_time;
   logic [NL-1:0] data_lane_ready, data_lane_active;
   logic          clk_lane_ready, clk_lane_active;
   logic [NL-1:0] data_lines_enable, data_ulps_rqst, lane_mask;
   logic          clk_lines_enable, clk_start_rqst, clk_fin_rqst, clk_ulps_rqst;
   logic          lines_ready, clock_ready, lanes_active, ulps_active, seq_error;

   logic [3:0] exp_mask;
   sb_t        sb_q[$];
   int         n_checks = 0;
   int         n_errors = 0;

   always #5 clk_phy = ~clk_phy;

   dphy_lanes_sequencer #(.NUM_LANES(NL), .TMR_W(TW)) dut (
      .clk_phy           (clk_phy),
      .rst_n             (rst_n),
      .lines_enable      (lines_enable),
      .clock_enable      (clock_enable),
      .ulps_request      (ulps_request),
      .reg_lanes_number  (reg_lanes_number),
      .seq_timeout       (seq_timeout),
      .wakeup_time       (wakeup_time),
      .data_lane_ready   (data_lane_ready),
      .data_lane_active  (data_lane_active),
      .clk_lane_ready    (clk_lane_ready),
      .clk_lane_active   (clk_lane_active),
      .data_lines_enable (data_lines_enable),
      .data_ulps_rqst    (data_ulps_rqst),
      .clk_lines_enable  (clk_lines_enable),
      .clk_start_rqst    (clk_start_rqst),
      .clk_fin_rqst      (clk_fin_rqst),
      .clk_ulps_rqst     (clk_ulps_rqst),
      .lines_ready       (lines_ready),
      .clock_ready       (clock_ready),
      .lanes_active      (lanes_active),
      .ulps_active       (ulps_active),
      .seq_error         (seq_error),
      .lane_mask         (lane_mask)
   );

   function automatic logic [20:0] obs_vec();
      return {data_lines_enable, data_ulps_rqst, clk_lines_enable, clk_start_rqst,
              clk_fin_rqst, clk_ulps_rqst, lines_ready, clock_ready, lanes_active,
              ulps_active, seq_error, lane_mask};
   endfunction

   // Expected outputs for a phase, using the bench's own mask and driven inputs.
   function automatic logic [20:0] exp_vec(input ph_e ph);
      logic [3:0] m;
      logic       en, rdy, act;
      m   = exp_mask;
      en  = !(ph == P_IDLE || ph == P_DIS || ph == P_ERR);
      rdy = ((data_lane_ready & m) == m) && clk_lane_ready;
      act = ((data_lane_active & m) != 4'b0);
      return {(en ? m : 4'b0), ((ph == P_ULPS) ? m : 4'b0), en,
              (ph == P_WCA || ph == P_LA), (ph == P_WCI), (ph == P_ULPS),
              (en && rdy), (ph == P_LA), act, (ph == P_ULPS), (ph == P_ERR), m};
   endfunction

   task automatic check_eq(input string tag, input logic [20:0] got, input logic [20:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic pop_check();
      sb_t item;
      if (sb_q.size() == 0) begin
         check_eq("sb_underflow", obs_vec(), ~obs_vec());
      end else begin
         item = sb_q.pop_front();
         check_eq(item.tag, obs_vec(), item.exp);
      end
   endtask

   // Predict the phase after the next edge, then compare once the edge has passed.
   task automatic tick(input ph_e ph, input string tag);
      sb_q.push_back('{tag, exp_vec(ph)});
      @(posedge clk_phy);
      #1;
      pop_check();
   endtask

   task automatic check_now(input ph_e ph, input string tag);
      sb_q.push_back('{tag, exp_vec(ph)});
      pop_check();
   endtask

   task automatic set_defaults();
      lines_enable     = 1'b0;
      clock_enable     = 1'b0;
      ulps_request     = 1'b0;
      reg_lanes_number = 4'd2;
      seq_timeout      = '0;
      wakeup_time      = '0;
      data_lane_ready  = 4'hF;
      data_lane_active = 4'h0;
      clk_lane_ready   = 1'b1;
      clk_lane_active  = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      set_defaults();
      exp_mask = 4'b0000;
      #12;
      check_now(P_IDLE, "reset");
      @(negedge clk_phy);
      rst_n = 1'b1;
      tick(P_IDLE, "idle_after_reset");

      // Two lanes requested; unmasked lanes not ready must not block.
      lines_enable    = 1'b1;
      clock_enable    = 1'b1;
      data_lane_ready = 4'b1110;
      exp_mask        = 4'b0011;
      tick(P_EN, "t1_enter_enable");
      tick(P_EN, "t1_lane0_not_ready");
      data_lane_ready = 4'b0011;
      tick(P_WCA, "t1_unmasked_ignored");
      tick(P_WCA, "t1_wca_hold");
      clk_lane_active = 1'b1;
      tick(P_LA, "t1_clock_ready");

      // Clock stop while lane 0 stays busy for 10 cycles.
      data_lane_active = 4'b0001;
      tick(P_LA, "t2_busy");
      clock_enable = 1'b0;
      lines_enable = 1'b0;
      tick(P_WDI, "t2_wait_data_idle");
      for (int i = 0; i < 9; i++) tick(P_WDI, "t2_fin_held");
      data_lane_active = 4'b0000;
      tick(P_WCI, "t2_clk_fin");
      clk_lane_active = 1'b0;
      tick(P_DIS, "t2_disable");
      tick(P_IDLE, "t2_idle");

      // Request beyond range clamps to all lanes; ULPS entry and wakeup.
      reg_lanes_number = 4'd9;
      lines_enable     = 1'b1;
      clock_enable     = 1'b1;
      data_lane_ready  = 4'hF;
      exp_mask         = 4'b1111;
      tick(P_EN, "t3_mask_clamp_hi");
      tick(P_WCA, "t3_wca");
      clk_lane_active = 1'b1;
      tick(P_LA, "t3_la");
      ulps_request     = 1'b1;
      wakeup_time      = TW'(3);
      data_lane_active = 4'b0100;
      tick(P_LA, "t3_ulps_blocked");
      data_lane_active = 4'b0000;
      tick(P_ULPS, "t3_ulps_enter");
      for (int i = 0; i < 19; i++) tick(P_ULPS, "t3_ulps_hold");
      ulps_request = 1'b0;
      for (int i = 0; i < 4; i++) tick(P_WAKE, "t3_wakeup");
      tick(P_WCA, "t3_start_reassert");
      tick(P_LA, "t3_relock");

      // Asynchronous reset while in ULPS.
      ulps_request = 1'b1;
      tick(P_ULPS, "t5_ulps");
      #2;
      rst_n    = 1'b0;
      exp_mask = 4'b0000;
      #1;
      check_now(P_IDLE, "t5_async_reset");
      tick(P_IDLE, "t5_reset_hold");
      set_defaults();
      @(negedge clk_phy);
      rst_n = 1'b1;
      tick(P_IDLE, "t5_restart");

      // Zero lane request clamps to lane 0; handshake timeout of 5 cycles.
      reg_lanes_number = 4'd0;
      seq_timeout      = TW'(5);
      lines_enable     = 1'b1;
      clock_enable     = 1'b1;
      exp_mask         = 4'b0001;
      tick(P_EN, "t4_mask_clamp_lo");
      tick(P_WCA, "t4_wca_entry");
      for (int i = 0; i < 4; i++) tick(P_WCA, "t4_wca_wait");
      tick(P_ERR, "t4_error");
      tick(P_ERR, "t4_error_sticky");
      tick(P_ERR, "t4_error_sticky2");
      lines_enable = 1'b0;
      tick(P_IDLE, "t4_error_clear");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
